// File: rtl/tic_tac_toe_nxn.sv
// tic_tac_toe_nxn: N x N board, K-in-a-row win, valid/ready move entry with a 4-cycle line check
//
// Ports
//   clk_i          clock, rising edge
//   rst_ni         asynchronous active-low reset, clears all state
//   new_game_i     synchronous clear to the post-reset state, overrides every other input
//   move_valid_i   move request
//   move_idx_i     target cell, index = row*N + col
//   move_ready_o   high only while waiting for a move
//   move_err_o     one-cycle pulse after an accepted illegal move
//   board_o        cell c at [2c+1:2c]; 00 empty, 01 P1, 10 P2
//   turn_o         0 = P1 to move, 1 = P2 to move
//   move_count_o   number of legal moves placed
//   p1_win_o       sticky P1 win
//   p2_win_o       sticky P2 win
//   grid_full_o    sticky draw
//   game_over_o    any of the three above
//   timeout_o      sticky forfeit indicator (only when TURN_TIMER_EN is defined)
//
// Optional feature macro: TURN_TIMER_EN adds a per-turn idle timer of TIMEOUT_CYCLES cycles;
// the player to move forfeits when it expires.
module tic_tac_toe_nxn #(
    parameter int N              = 3,
    parameter int K              = 3,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int IDX_W         = $clog2(N * N),
    localparam int CNT_W         = $clog2(N * N + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 new_game_i,
    input  logic                 move_valid_i,
    input  logic [IDX_W-1:0]     move_idx_i,
    output logic                 move_ready_o,
    output logic                 move_err_o,
    output logic [2*N*N-1:0]     board_o,
    output logic                 turn_o,
    output logic [CNT_W-1:0]     move_count_o,
    output logic                 p1_win_o,
    output logic                 p2_win_o,
    output logic                 grid_full_o,
    output logic                 game_over_o
`ifdef TURN_TIMER_EN
    ,
    output logic                 timeout_o
`endif
);
    localparam int RC_W = $clog2(N);

    typedef enum logic [2:0] {PLAY, CHK0, CHK1, CHK2, CHK3, DONE} state_e;

    state_e             state_q;
    logic [2*N*N-1:0]   board_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [RC_W-1:0]    row_q, col_q;
    logic               turn_q, ready_q, err_q, p1_q, p2_q, full_q, hit_q;
    logic [1:0]         mark;
    logic               accept, in_range, legal, hit_d;
`ifdef TURN_TIMER_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0]      timer_q;
    logic               timeout_q;
    assign timeout_o = timeout_q;
`endif

    assign mark     = turn_q ? 2'b10 : 2'b01;
    assign accept   = move_valid_i & ready_q;
    assign in_range = int'(move_idx_i) < N * N;
    // clamp the index so an out-of-range request never selects outside the board
    assign legal    = in_range && board_q[2*(in_range ? int'(move_idx_i) : 0) +: 2] == 2'b00;

    // Run length through the latched cell along the direction owned by the current CHK state.
    // Each side stops at the first foreign/empty cell or at the board edge (no wrap).
    always_comb begin
        int dr, dc, rr, cc, run, idx;
        logic go, inb;
        dr  = (state_q == CHK0) ? 0 : 1;
        dc  = (state_q == CHK1) ? 0 : (state_q == CHK3) ? -1 : 1;
        run = 1;
        for (int s = -1; s <= 1; s += 2) begin
            go = 1'b1;
            for (int k = 1; k < K; k++) begin
                rr  = int'(row_q) + s * k * dr;
                cc  = int'(col_q) + s * k * dc;
                inb = rr >= 0 && rr < N && cc >= 0 && cc < N;
                idx = inb ? rr * N + cc : 0;
                go  = go && inb && board_q[2*idx +: 2] == mark;
                run = go ? run + 1 : run;
            end
        end
        hit_d = hit_q | (run >= K);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= PLAY;
            board_q   <= '0;
            cnt_q     <= '0;
            row_q     <= '0;
            col_q     <= '0;
            turn_q    <= 1'b0;
            ready_q   <= 1'b1;
            err_q     <= 1'b0;
            p1_q      <= 1'b0;
            p2_q      <= 1'b0;
            full_q    <= 1'b0;
            hit_q     <= 1'b0;
`ifdef TURN_TIMER_EN
            timer_q   <= '0;
            timeout_q <= 1'b0;
`endif
        end else if (new_game_i) begin
            state_q   <= PLAY;
            board_q   <= '0;
            cnt_q     <= '0;
            row_q     <= '0;
            col_q     <= '0;
            turn_q    <= 1'b0;
            ready_q   <= 1'b1;
            err_q     <= 1'b0;
            p1_q      <= 1'b0;
            p2_q      <= 1'b0;
            full_q    <= 1'b0;
            hit_q     <= 1'b0;
`ifdef TURN_TIMER_EN
            timer_q   <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            err_q <= 1'b0;
            case (state_q)
                PLAY: begin
                    if (accept && !legal) begin
                        err_q <= 1'b1;
                    end else if (accept) begin
                        board_q[2*move_idx_i +: 2] <= mark;
                        cnt_q   <= cnt_q + 1'b1;
                        row_q   <= RC_W'(int'(move_idx_i) / N);
                        col_q   <= RC_W'(int'(move_idx_i) % N);
                        hit_q   <= 1'b0;
                        ready_q <= 1'b0;
                        state_q <= CHK0;
                    end
`ifdef TURN_TIMER_EN
                    timer_q <= accept ? '0 : timer_q + 1'b1;
                    // idle player forfeits; the opponent of the player to move wins
                    if (!accept && timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                        p1_q      <= turn_q;
                        p2_q      <= !turn_q;
                        timeout_q <= 1'b1;
                        ready_q   <= 1'b0;
                        state_q   <= DONE;
                    end
`endif
                end
                CHK0, CHK1, CHK2: begin
                    hit_q   <= hit_d;
                    state_q <= state_q == CHK0 ? CHK1 : state_q == CHK1 ? CHK2 : CHK3;
                end
                CHK3: begin
                    if (hit_d) begin
                        p1_q    <= !turn_q;
                        p2_q    <= turn_q;
                        state_q <= DONE;
                    end else if (cnt_q == CNT_W'(N * N)) begin
                        full_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        turn_q  <= !turn_q;
                        ready_q <= 1'b1;
                        state_q <= PLAY;
                    end
                end
                default: ;
            endcase
        end
    end

    assign move_ready_o = ready_q;
    assign move_err_o   = err_q;
    assign board_o      = board_q;
    assign turn_o       = turn_q;
    assign move_count_o = cnt_q;
    assign p1_win_o     = p1_q;
    assign p2_win_o     = p2_q;
    assign grid_full_o  = full_q;
    assign game_over_o  = p1_q | p2_q | full_q;
endmodule

// File: tb/tb_tic_tac_toe_nxn.sv
// tb_tic_tac_toe_nxn: directed checks of tic_tac_toe_nxn on a 3x3/K3 and a 5x5/K4 board
module tb_tic_tac_toe_nxn;
    logic        clk = 1'b0;
    logic        rst_n, new_game, mv;
    logic [4:0]  idx;
    int          errors = 0;
    int          checks = 0;

    logic        r3, e3, t3, w13, w23, f3, go3;
    logic [17:0] b3;
    logic [3:0]  c3;
    logic        r5, e5, t5, w15, w25, f5, go5;
    logic [49:0] b5;
    logic [4:0]  c5;
`ifdef TURN_TIMER_EN
    logic        to3, to5, rt, et, tt, w1t, w2t, ft, got, tot;
    logic [17:0] bt;
    logic [3:0]  ct;
`endif

    always #5 clk = ~clk;

    tic_tac_toe_nxn #(.N(3), .K(3)) u3 (
        .clk_i(clk), .rst_ni(rst_n), .new_game_i(new_game), .move_valid_i(mv),
        .move_idx_i(idx[3:0]), .move_ready_o(r3), .move_err_o(e3), .board_o(b3),
        .turn_o(t3), .move_count_o(c3), .p1_win_o(w13), .p2_win_o(w23),
        .grid_full_o(f3), .game_over_o(go3)
`ifdef TURN_TIMER_EN
        , .timeout_o(to3)
`endif
    );

    tic_tac_toe_nxn #(.N(5), .K(4)) u5 (
        .clk_i(clk), .rst_ni(rst_n), .new_game_i(new_game), .move_valid_i(mv),
        .move_idx_i(idx), .move_ready_o(r5), .move_err_o(e5), .board_o(b5),
        .turn_o(t5), .move_count_o(c5), .p1_win_o(w15), .p2_win_o(w25),
        .grid_full_o(f5), .game_over_o(go5)
`ifdef TURN_TIMER_EN
        , .timeout_o(to5)
`endif
    );

`ifdef TURN_TIMER_EN
    tic_tac_toe_nxn #(.N(3), .K(3), .TIMEOUT_CYCLES(8)) ut (
        .clk_i(clk), .rst_ni(rst_n), .new_game_i(new_game), .move_valid_i(mv),
        .move_idx_i(idx[3:0]), .move_ready_o(rt), .move_err_o(et), .board_o(bt),
        .turn_o(tt), .move_count_o(ct), .p1_win_o(w1t), .p2_win_o(w2t),
        .grid_full_o(ft), .game_over_o(got), .timeout_o(tot)
    );
`endif

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int i);
        @(negedge clk);
        mv  = 1'b1;
        idx = 5'(i);
        @(negedge clk);
        mv  = 1'b0;
    endtask

    task automatic play(input int i);
        drive(i);
        repeat (4) @(negedge clk);
    endtask

    task automatic ng();
        @(negedge clk);
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
    endtask

    int draw_seq[9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
    int anti_seq[7] = '{4, 0, 8, 1, 12, 2, 16};
    int wrap_seq[7] = '{3, 10, 4, 11, 5, 15, 6};

    initial begin
        rst_n = 1'b0; new_game = 1'b0; mv = 1'b0; idx = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_board", b3, 0);
        chk("rst_turn", t3, 0);
        chk("rst_count", c3, 0);
        chk("rst_ready", r3, 1);
        chk("rst_err", e3, 0);
        chk("rst_over", go3, 0);

        // row win for P1
        play(0);
        chk("t1_cell0", b3[1:0], 2'b01);
        chk("t1_turn", t3, 1);
        chk("t1_count", c3, 1);
        chk("t1_ready", r3, 1);
        play(3); play(1); play(4);
        drive(2);
        chk("t1_busy", r3, 0);
        repeat (3) @(negedge clk);
        chk("t1_nowin_e3", w13, 0);
        @(negedge clk);
        chk("t1_p1win", w13, 1);
        chk("t1_p2win", w23, 0);
        chk("t1_full", f3, 0);
        chk("t1_count5", c3, 5);
        chk("t1_ready0", r3, 0);
        chk("t1_over", go3, 1);
        drive(8);
        chk("done_noerr", e3, 0);
        chk("done_count", c3, 5);
        chk("done_cell8", b3[17:16], 2'b00);

        // new_game together with a move drops the move
        @(negedge clk);
        new_game = 1'b1; mv = 1'b1; idx = 5'd4;
        @(negedge clk);
        new_game = 1'b0; mv = 1'b0;
        chk("ng_board", b3, 0);
        chk("ng_count", c3, 0);
        chk("ng_win", w13, 0);
        chk("ng_ready", r3, 1);
        chk("ng_turn", t3, 0);

        // illegal moves
        play(0);
        drive(0);
        chk("occ_err", e3, 1);
        chk("occ_turn", t3, 1);
        chk("occ_count", c3, 1);
        @(negedge clk);
        chk("occ_err_clr", e3, 0);
        drive(9);
        chk("oor_err", e3, 1);
        chk("oor_count", c3, 1);
        chk("oor_board", b3, 18'h1);
        chk("oor_ready", r3, 1);
        @(negedge clk);
        chk("oor_err_clr", e3, 0);

        // draw
        ng();
        foreach (draw_seq[i]) play(draw_seq[i]);
        chk("draw_full", f3, 1);
        chk("draw_p1", w13, 0);
        chk("draw_p2", w23, 0);
        chk("draw_count", c3, 9);
        chk("draw_over", go3, 1);
        chk("draw_board", b3, {2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01, 2'b10, 2'b01});

        // 5x5 K=4 anti-diagonal win
        ng();
        foreach (anti_seq[i]) play(anti_seq[i]);
        chk("anti_p1win", w15, 1);
        chk("anti_p2win", w25, 0);
        chk("anti_count", c5, 7);

        // 5x5 K=4 row run must not wrap across the edge
        ng();
        foreach (wrap_seq[i]) play(wrap_seq[i]);
        chk("wrap_nowin", w15, 0);
        chk("wrap_turn", t5, 1);
        chk("wrap_count", c5, 7);
        chk("wrap_ready", r5, 1);
        chk("wrap_cell6", b5[13:12], 2'b01);

        // async reset while checking a winning move
        ng();
        play(0); play(3); play(1); play(4);
        drive(2);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_board", b3, 0);
        chk("arst_count", c3, 0);
        chk("arst_win", w13, 0);
        chk("arst_over", go3, 0);
        chk("arst_turn", t3, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("arst_nolate", w13, 0);
        chk("arst_ready", r3, 1);
        play(4);
        chk("arst_move", b3[9:8], 2'b01);
        chk("arst_turn1", t3, 1);

`ifdef TURN_TIMER_EN
        ng();
        play(0);
        repeat (7) @(negedge clk);
        chk("tmo_early", w1t, 0);
        @(negedge clk);
        chk("tmo_p1win", w1t, 1);
        chk("tmo_flag", tot, 1);
        chk("tmo_over", got, 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
